count_event_monitor: RTL

Synthesizable checker that watches the 4-bit count output of the e2e counter-with-assert DUT and turns its assertion condition and any sequencing faults into timestamped event records. Records go into a small FIFO drained over a valid/ready stream, so the GPU simulator and an RTL bench see the same assertion events without relying on `$display`. It sits beside the DUT, on the consuming end of the count interface.

---
 rtl/count_event_monitor.sv | 106 ++++++++++
 1 files changed

// File: rtl/count_event_monitor.sv
// Watches a free-running counter and queues timestamped LIMIT_HIT / SEQ_ERR records for a valid/ready consumer.
// Optional stop-on-limit behaviour is enabled by defining COUNT_EVENT_MONITOR_STOP_EN.
module count_event_monitor #(
  parameter int WIDTH    = 4,
  parameter int LIMIT    = 10,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             count,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [2+WIDTH+TS_WIDTH-1:0]  evt_data,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt,
  output logic                         halt
);
  localparam int REC_W = 2 + WIDTH + TS_WIDTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] LIM  = WIDTH'(LIMIT);
  localparam logic [AW:0]      FULL = (AW+1)'(DEPTH);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                armed_q, armed_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d;
  logic [REC_W-1:0]    mem_q [DEPTH];

  logic             limit_hit, seq_err, push_req, push_ok, pop, full, drop;
  logic [REC_W-1:0] rec;
  logic             halt_q;

  always_comb begin
    limit_hit = (count == LIM);
    seq_err   = armed_q && (count != WIDTH'(prev_q + 1'b1));
    rec       = {seq_err, limit_hit, count, ts_q};
    push_req  = (limit_hit | seq_err) & ~halt_q;
    pop       = evt_valid & evt_ready;
    full      = (cnt_q == FULL);
    // A pop frees the slot in the same edge, so a full FIFO can still accept.
    push_ok   = push_req & (~full | pop);
    drop      = push_req & full & ~pop;

    ts_d    = ts_q + 1'b1;
    armed_d = 1'b1;
    prev_d  = count;
    wr_d    = push_ok ? AW'(wr_q + 1'b1) : wr_q;
    rd_d    = pop ? AW'(rd_q + 1'b1) : rd_q;
    cnt_d   = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d  = ovf_q | drop;
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      armed_q <= 1'b0;
      prev_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      ts_q    <= ts_d;
      armed_q <= armed_d;
      prev_q  <= prev_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible while cnt_q covers them.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_q] <= rec;
  end

`ifdef COUNT_EVENT_MONITOR_STOP_EN
  logic halt_d;
  always_comb halt_d = halt_q | (push_ok & limit_hit);
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`else
  assign halt_q = 1'b0;
`endif

  assign evt_valid = (cnt_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_q] : '0;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  assign halt      = halt_q;
endmodule
